// File: rtl/snd_dma_addr.sv
// snd_dma_addr -- sound DMA word-address generator.
//
// A CPU-programmed start/end word-address pair defines a sound frame. While
// enabled, each sadv pulse steps snd toward sft; reaching sft ends the frame
// (sfend pulse) and either reloads the frame (repeat mode) or stops the DMA.
// Start/end registers are shadowed: they only reach snd/sft on a frame load.
//
// Ports:
//   clk32          system clock, rising edge
//   por            synchronous active-high power-on reset
//   reg_we/reg_re  one-cycle CPU write/read strobes
//   reg_a[4:0]     register index (byte address bits [5:1])
//   reg_di[7:0]    CPU write data
//   reg_do[7:0]    registered CPU read data
//   sadv           one-cycle advance pulse per fetched sound word
//   snd[21:1]      current sound word address
//   sft[21:1]      active frame end address
//   sndon          DMA enabled
//   sfrep          frame repeat mode
//   sfend          one-cycle frame-end pulse
//
// Register map: 0x00 control {sfrep,sndon}; 0x01-0x03 start hi/mid/lo;
// 0x04-0x06 counter hi/mid/lo (read-only); 0x07-0x09 end hi/mid/lo.
//
// Build option: define SND_DMA_RDBACK_EN to enable register readback; when
// undefined reg_do is tied to 0x00 and no read path exists.
module snd_dma_addr (
  input  logic        clk32,
  input  logic        por,
  input  logic        reg_we,
  input  logic        reg_re,
  input  logic [4:0]  reg_a,
  input  logic [7:0]  reg_di,
  output logic [7:0]  reg_do,
  input  logic        sadv,
  output logic [21:1] snd,
  output logic [21:1] sft,
  output logic        sndon,
  output logic        sfrep,
  output logic        sfend
);

  localparam logic [4:0] A_CTRL    = 5'h00;
  localparam logic [4:0] A_ST_HI   = 5'h01;
  localparam logic [4:0] A_ST_MID  = 5'h02;
  localparam logic [4:0] A_ST_LO   = 5'h03;
  localparam logic [4:0] A_CNT_HI  = 5'h04;
  localparam logic [4:0] A_CNT_MID = 5'h05;
  localparam logic [4:0] A_CNT_LO  = 5'h06;
  localparam logic [4:0] A_END_HI  = 5'h07;
  localparam logic [4:0] A_END_MID = 5'h08;
  localparam logic [4:0] A_END_LO  = 5'h09;

  logic [21:1] start_r, end_r;
  logic [21:1] start_nxt, end_nxt;
  logic [21:1] snd_nxt, sft_nxt;
  logic        sndon_nxt, sfrep_nxt, sfend_nxt;
  logic        ctrl_we, load;

  assign ctrl_we = reg_we && (reg_a == A_CTRL);

  // Start/end next values; a frame load in the same cycle as a byte write
  // picks up the freshly written byte.
  always_comb begin
    start_nxt = start_r;
    end_nxt   = end_r;
    if (reg_we) begin
      case (reg_a)
        A_ST_HI:  start_nxt[21:16] = reg_di[5:0];
        A_ST_MID: start_nxt[15:8]  = reg_di;
        A_ST_LO:  start_nxt[7:1]   = reg_di[7:1];
        A_END_HI: end_nxt[21:16]   = reg_di[5:0];
        A_END_MID: end_nxt[15:8]   = reg_di;
        A_END_LO: end_nxt[7:1]     = reg_di[7:1];
        default: ;
      endcase
    end
  end

  // Control write is evaluated before the advance: a disabling write
  // swallows a coincident sadv, and the frame-end decision uses the
  // newly written repeat bit.
  always_comb begin
    sndon_nxt = sndon;
    sfrep_nxt = sfrep;
    snd_nxt   = snd;
    sft_nxt   = sft;
    sfend_nxt = 1'b0;
    load      = 1'b0;
    if (ctrl_we) begin
      sfrep_nxt = reg_di[1];
      if (!reg_di[0]) begin
        sndon_nxt = 1'b0;
      end else if (!sndon) begin
        sndon_nxt = 1'b1;
        load      = 1'b1;
      end
    end
    if (sadv && sndon && !(ctrl_we && !reg_di[0])) begin
      if (snd != sft) begin
        snd_nxt = snd + 21'd1;
      end else begin
        sfend_nxt = 1'b1;
        if (sfrep_nxt) load = 1'b1;
        else           sndon_nxt = 1'b0;
      end
    end
    if (load) begin
      snd_nxt = start_nxt;
      sft_nxt = end_nxt;
    end
  end

  always_ff @(posedge clk32) begin
    if (por) begin
      sndon   <= 1'b0;
      sfrep   <= 1'b0;
      sfend   <= 1'b0;
      snd     <= '0;
      sft     <= '0;
      start_r <= '0;
      end_r   <= '0;
    end else begin
      sndon   <= sndon_nxt;
      sfrep   <= sfrep_nxt;
      sfend   <= sfend_nxt;
      snd     <= snd_nxt;
      sft     <= sft_nxt;
      start_r <= start_nxt;
      end_r   <= end_nxt;
    end
  end

`ifdef SND_DMA_RDBACK_EN
  logic [7:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (reg_a)
      A_CTRL:    rd_mux = {6'b0, sfrep, sndon};
      A_ST_HI:   rd_mux = {2'b0, start_r[21:16]};
      A_ST_MID:  rd_mux = start_r[15:8];
      A_ST_LO:   rd_mux = {start_r[7:1], 1'b0};
      A_CNT_HI:  rd_mux = {2'b0, snd[21:16]};
      A_CNT_MID: rd_mux = snd[15:8];
      A_CNT_LO:  rd_mux = {snd[7:1], 1'b0};
      A_END_HI:  rd_mux = {2'b0, end_r[21:16]};
      A_END_MID: rd_mux = end_r[15:8];
      A_END_LO:  rd_mux = {end_r[7:1], 1'b0};
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk32) begin
    if (por)         reg_do <= '0;
    else if (reg_re) reg_do <= rd_mux;
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, reg_di[0]};
`else
  assign reg_do = '0;

  logic unused_bits;
  assign unused_bits = &{1'b0, reg_di[0], reg_re};
`endif

endmodule

// File: tb/tb_snd_dma_addr.sv
// Bench for snd_dma_addr: directed frame scenarios plus randomized traffic,
// every cycle compared against a word-address reference model.
module tb_snd_dma_addr;

  logic        clk32 = 1'b0;
  logic        por, reg_we, reg_re, sadv;
  logic [4:0]  reg_a;
  logic [7:0]  reg_di, reg_do;
  logic [21:1] snd, sft;
  logic        sndon, sfrep, sfend;

  snd_dma_addr dut (
    .clk32(clk32), .por(por), .reg_we(reg_we), .reg_re(reg_re),
    .reg_a(reg_a), .reg_di(reg_di), .reg_do(reg_do), .sadv(sadv),
    .snd(snd), .sft(sft), .sndon(sndon), .sfrep(sfrep), .sfend(sfend)
  );

  always #5 clk32 = ~clk32;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned fend_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: addresses kept as plain word numbers modulo 2^21.
  localparam int unsigned WRAP = 32'h0020_0000;
  int unsigned m_on, m_rep, m_fend, m_snd, m_sft, m_start, m_end, m_do;

  function automatic int unsigned put_byte(input int unsigned w,
                                           input int unsigned pos,
                                           input int unsigned d);
    case (pos)
      0:       return (w % 32768) + (d % 64) * 32768;
      1:       return (w / 32768) * 32768 + d * 128 + (w % 128);
      default: return (w / 128) * 128 + d / 2;
    endcase
  endfunction

  function automatic int unsigned get_byte(input int unsigned w,
                                           input int unsigned pos);
    case (pos)
      0:       return (w / 32768) % 64;
      1:       return (w / 128) % 256;
      default: return (w % 128) * 2;
    endcase
  endfunction

  task automatic model_step(input bit we, input bit re, input int unsigned a,
                            input int unsigned di, input bit adv, input bit rst);
    int unsigned ns, ne, rd;
    bit stop_w, go_w;
    if (rst) begin
      m_on = 0; m_rep = 0; m_fend = 0; m_snd = 0; m_sft = 0;
      m_start = 0; m_end = 0; m_do = 0;
      return;
    end
    ns = m_start;
    ne = m_end;
    if (we && a >= 1 && a <= 3) ns = put_byte(ns, a - 1, di);
    if (we && a >= 7 && a <= 9) ne = put_byte(ne, a - 7, di);
    rd = 0;
    case (a)
      0:       rd = m_rep * 2 + m_on;
      1, 2, 3: rd = get_byte(m_start, a - 1);
      4, 5, 6: rd = get_byte(m_snd, a - 4);
      7, 8, 9: rd = get_byte(m_end, a - 7);
      default: rd = 0;
    endcase
`ifdef SND_DMA_RDBACK_EN
    if (re) m_do = rd;
`else
    if (re) m_do = 0;
`endif
    stop_w = we && a == 0 && (di % 2) == 0;
    go_w   = we && a == 0 && (di % 2) == 1 && m_on == 0;
    if (we && a == 0) m_rep = (di / 2) % 2;
    m_fend = 0;
    if (go_w) begin
      m_on = 1; m_snd = ns; m_sft = ne;
    end else if (stop_w) begin
      m_on = 0;
    end else if (m_on == 1 && adv) begin
      if (m_snd != m_sft) begin
        m_snd = (m_snd + 1) % WRAP;
      end else begin
        m_fend = 1;
        if (m_rep == 1) begin
          m_snd = ns; m_sft = ne;
        end else begin
          m_on = 0;
        end
      end
    end
    m_start = ns;
    m_end   = ne;
  endtask

  task automatic cyc(input bit we, input bit re, input int unsigned a,
                     input int unsigned di, input bit adv, input bit rst);
    reg_we = we; reg_re = re; reg_a = 5'(a); reg_di = 8'(di);
    sadv = adv; por = rst;
    model_step(we, re, a, di, adv, rst);
    @(posedge clk32);
    #1;
    check_val("snd",    32'(snd),    m_snd);
    check_val("sft",    32'(sft),    m_sft);
    check_val("sndon",  32'(sndon),  m_on);
    check_val("sfrep",  32'(sfrep),  m_rep);
    check_val("sfend",  32'(sfend),  m_fend);
    check_val("reg_do", 32'(reg_do), m_do);
    if (sfend) fend_cnt++;
    reg_we = 0; reg_re = 0; sadv = 0; por = 0;
  endtask

  task automatic wr(input int unsigned a, input int unsigned d);
    cyc(1, 0, a, d, 0, 0);
  endtask

  task automatic set_start(input int unsigned w);
    wr(1, get_byte(w, 0)); wr(2, get_byte(w, 1)); wr(3, get_byte(w, 2));
  endtask

  task automatic set_end(input int unsigned w);
    wr(7, get_byte(w, 0)); wr(8, get_byte(w, 1)); wr(9, get_byte(w, 2));
  endtask

  task automatic advance(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    int unsigned op, a, d;
    reg_we = 0; reg_re = 0; reg_a = '0; reg_di = '0; sadv = 0; por = 1;

    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 4, 0, 0, 1);
    check_val("rst_snd", 32'(snd), 0);
    check_val("rst_on",  32'(sndon), 0);

    // One-shot four-word frame.
    set_start(32'h010000);
    set_end(32'h010003);
    wr(0, 1);
    check_val("load_snd", 32'(snd), 32'h010000);
    fend_cnt = 0;
    advance(3);
    check_val("step3_snd", 32'(snd), 32'h010003);
    advance(1);
    check_val("oneshot_fend", fend_cnt, 1);
    check_val("oneshot_on", 32'(sndon), 0);
    advance(2);
    check_val("oneshot_hold", 32'(snd), 32'h010003);

    // Repeat mode: two frames, reload to start after each.
    fend_cnt = 0;
    wr(0, 3);
    advance(8);
    check_val("rep_fend", fend_cnt, 2);
    check_val("rep_on", 32'(sndon), 1);
    check_val("rep_snd", 32'(snd), 32'h010000);

    // Shadowed end rewrite mid-frame.
    advance(1);
    set_end(32'h010001);
    check_val("shadow_sft", 32'(sft), 32'h010003);
    fend_cnt = 0;
    advance(3);
    check_val("shadow_fend", fend_cnt, 1);
    check_val("new_sft", 32'(sft), 32'h010001);
    advance(2);
    check_val("short_fend", fend_cnt, 2);
    wr(0, 0);

    // Wrap across the top of the address space.
    set_start(32'h1FFFFE);
    set_end(32'h000001);
    wr(0, 1);
    advance(2);
    check_val("wrap_snd", 32'(snd), 32'h000000);
    advance(2);
    check_val("wrap_end", 32'(sndon), 0);
    check_val("wrap_hold", 32'(snd), 32'h000001);

    // Disable write coinciding with sadv.
    set_start(32'h010000);
    set_end(32'h010003);
    wr(0, 1);
    advance(2);
    fend_cnt = 0;
    cyc(1, 0, 0, 0, 1, 0);
    check_val("stop_snd", 32'(snd), 32'h010002);
    check_val("stop_on", 32'(sndon), 0);
    check_val("stop_fend", fend_cnt, 0);

    // Reset mid-frame, then counter reads.
    wr(0, 1);
    advance(1);
    cyc(0, 0, 0, 0, 1, 1);
    check_val("por_snd", 32'(snd), 0);
    check_val("por_fend", 32'(sfend), 0);
    cyc(0, 1, 4, 0, 0, 0);
    cyc(0, 1, 5, 0, 0, 0);
    cyc(0, 1, 6, 0, 0, 0);
    check_val("por_cnt_lo", 32'(reg_do), 0);

    // Randomized traffic around a small address window.
    for (int unsigned i = 0; i < 4000; i++) begin
      op = $urandom_range(99);
      if (op < 1) begin
        cyc(0, 0, 0, 0, 0, 1);
      end else begin
        a = $urandom_range(15);
        if (a == 2 || a == 8)      d = $urandom_range(1) ? 8'h00 : 8'h01;
        else if (a == 1 || a == 7) d = $urandom_range(1) ? 8'h00 : 8'h3F;
        else if (a == 0)           d = ($urandom_range(9) < 8) ? (32'h1 | ($urandom_range(1) * 2)) : 32'($urandom_range(255));
        else                       d = $urandom_range(255);
        cyc(op < 12, $urandom_range(4) == 0, a, d, $urandom_range(1) == 1, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/snd_dma_addr.md
SND_DMA_ADDR -- requirements
Module: snd_dma_addr

Interface
REQ-001 clk32  in  1  system clock; all state updates on rising edge.
REQ-002 por  in  1  power-on reset, synchronous, active-high.
REQ-003 reg_we  in  1  one-cycle CPU register write strobe.
REQ-004 reg_re  in  1  one-cycle CPU register read strobe.
REQ-005 reg_a  in  5  register select, byte address bits [5:1].
REQ-006 reg_di  in  8  CPU write data.
REQ-007 reg_do  out  8  CPU read data, registered.
REQ-008 sadv  in  1  one-cycle advance pulse, one per fetched sound word.
REQ-009 snd  out  21  current sound word address [21:1].
REQ-010 sft  out  21  active frame end address [21:1].
REQ-011 sndon  out  1  sound DMA enabled.
REQ-012 sfrep  out  1  frame repeat mode.
REQ-013 sfend  out  1  one-cycle pulse at frame end.

Function
REQ-014 Register map (reg_a): 0x00 control (bit0 sndon, bit1 sfrep); 0x01/0x02/0x03 start hi/mid/lo; 0x04/0x05/0x06 counter hi/mid/lo (read-only); 0x07/0x08/0x09 end hi/mid/lo; other indices: writes ignored.
REQ-015 Hi byte holds address bits [21:16] in reg_di[5:0]; mid holds [15:8]; lo holds [7:1] in reg_di[7:1], reg_di[0] ignored.
REQ-016 start_r and end_r written by CPU SHALL NOT affect snd/sft until next frame load.
REQ-017 Frame load: snd <= start_r, sft <= end_r, same cycle.
REQ-018 Control write with bit0=1 while sndon=0: sndon <= 1 and frame load in the same cycle.
REQ-019 Control write with bit0=1 while sndon=1: no frame load; only sfrep updated.
REQ-020 Control write with bit0=0: sndon <= 0 next cycle; snd and sft hold.
REQ-021 sfrep follows control bit1 on every control write, independent of sndon.
REQ-022 sadv ignored while sndon=0.
REQ-023 sadv with sndon=1 and snd != sft: snd <= snd + 1, modulo 2^21 (0x1FFFFF wraps to 0x000000).
REQ-024 sadv with sndon=1 and snd == sft: sfend pulses next cycle; if sfrep=1 frame load; else sndon <= 0 and snd holds.
REQ-025 Frame length SHALL be end-start+1 words inclusive; start == end gives one-word frame.
REQ-026 Control write and sadv in same cycle: control write evaluated first; bit0=0 write suppresses the advance; bit0=1 write to running DMA lets the advance proceed.
REQ-027 Start/end write and frame-end reload in same cycle: reload uses the newly written byte.
REQ-028 reg_do updated one cycle after reg_re; holds otherwise; unused bits and unmapped indices read 0.

Reset
REQ-029 por=1: sndon=0, sfrep=0, sfend=0, snd=0, sft=0, start_r=0, end_r=0, reg_do=0.
REQ-030 por asserted mid-frame aborts the frame at the next edge; no sfend pulse.

Configuration
REQ-031 Macro SND_DMA_RDBACK_EN defined: reg_do returns control, start, counter (live snd) and end registers per REQ-014.
REQ-032 SND_DMA_RDBACK_EN undefined: reg_do constant 0x00, read path and readback muxes absent; all other behaviour unchanged.

Verification
REQ-033 Start 0x010000, end 0x010003, control 0x01, 4 sadv -> snd 0x010000..0x010003, sfend once, sndon=0, snd holds 0x010003.
REQ-034 Same frame, control 0x03, 8 sadv -> two sfend pulses, snd back to 0x010000 after each, sndon stays 1.
REQ-035 Repeat running, end rewritten to 0x010001 mid-frame -> current frame ends at 0x010003, next frame ends at 0x010001.
REQ-036 Start 0x1FFFFE, end 0x000001, control 0x01 -> snd 0x1FFFFE, 0x1FFFFF, 0x000000, 0x000001, then stop.
REQ-037 Control 0x00 written in same cycle as sadv at snd 0x010002 -> sndon=0, snd stays 0x010002, no sfend.
REQ-038 por pulsed mid-frame -> all outputs 0 next cycle; with SND_DMA_RDBACK_EN, counter read returns 0x00 for hi/mid/lo.
